// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter between NUM_REQ requesters.
// Tracks the transmitter's busy flag through a 2-flop synchronizer.
//
// state  | meaning
// IDLE   | waiting for a free transmitter and a pending request
// GRANT  | byte latched; raise the start strobe
// STROBE | strobe held until busy_s rises or the timeout expires
// DRAIN  | byte accepted; waiting for the frame to finish
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int STB_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_stb,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 active,
  output logic                 timeout_err
);

  localparam int CW = (STB_TIMEOUT > 2) ? $clog2(STB_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STB_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, STROBE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [2:0]           rr_q, rr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_m, busy_s;
  logic [1:0]           fill_q, fill_d;
  logic [NUM_REQ-1:0]   req_ack_d;
  logic                 tx_stb_d;
  logic [7:0]           tx_data_d;
  logic [2:0]           grant_d;
  logic                 active_d;
  logic                 terr_d;

  logic [2:0]           sel_idx;
  logic [7:0]           sel_byte;
  logic                 sel_found;
  logic [2:0]           rr_next;

  // First pending requester scanning from rr upwards with wrap.
  always_comb begin
    sel_idx   = '0;
    sel_byte  = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (int'(rr_q) + k) % NUM_REQ;
      if (!sel_found && req_valid[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        sel_byte  = req_data[8*i +: 8];
      end
    end
  end

  assign rr_next = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    fill_d    = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    req_ack_d = '0;
    tx_stb_d  = tx_stb;
    tx_data_d = tx_data;
    grant_d   = grant_id;
    active_d  = active;
    terr_d    = timeout_err;
    case (state_q)
      IDLE: begin
        // fill_q keeps IDLE from trusting busy_s until the synchronizer has refilled after reset
        if (fill_q == 2'd2 && !busy_s && sel_found) begin
          grant_d   = sel_idx;
          tx_data_d = sel_byte;
          active_d  = 1'b1;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        tx_stb_d = 1'b1;
        cnt_d    = '0;
        state_d  = STROBE;
      end
      STROBE: begin
        if (busy_s) begin
          tx_stb_d = 1'b0;
          for (int k = 0; k < NUM_REQ; k++) req_ack_d[k] = (3'(k) == grant_id);
          rr_d     = rr_next;
          state_d  = DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          tx_stb_d = 1'b0;
          terr_d   = 1'b1;
          active_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!busy_s) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      cnt_q       <= '0;
      busy_m      <= 1'b0;
      busy_s      <= 1'b0;
      fill_q      <= '0;
      req_ack     <= '0;
      tx_stb      <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      busy_m      <= tx_busy;
      busy_s      <= busy_m;
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      req_ack     <= req_ack_d;
      tx_stb      <= tx_stb_d;
      tx_data     <= tx_data_d;
      grant_id    <= grant_d;
      active      <= active_d;
      timeout_err <= terr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a behavioural transmitter answers the strobe,
// and expected (requester, byte) pairs are queued and matched against each req_ack pulse.
module tb_uart_tx_arbiter;

  localparam int NR       = 4;
  localparam int TMO      = 16;
  localparam int BUSY_DLY = 5;
  localparam int BUSY_LEN = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = {8'h44, 8'h43, 8'h42, 8'h41};
  logic [NR-1:0]   req_ack;
  logic            tx_stb;
  logic [7:0]      tx_data;
  logic            tx_busy = 1'b0;
  logic [2:0]      grant_id;
  logic            active;
  logic            timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .STB_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_stb(tx_stb), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t    q[$];
  int      checks = 0;
  int      errors = 0;
  int      acks = 0;
  int      mode = 0;        // 0: transmitter model passive, 1: answers the strobe
  int      hi_cnt = 0;
  int      busy_cnt = 0;
  int      stb_run = 0;
  int      last_stb_len = 0;
  bit      stb_fell = 1'b0;
  bit      in_drain = 1'b0;
  logic [NR-1:0] keep = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_tx(input int id);
    exp_t e;
    e.id   = 3'(id);
    e.data = req_data[8*id +: 8];
    q.push_back(e);
  endtask

  // One clock: sample at the falling edge, score acks, then run the transmitter model.
  task automatic step();
    @(negedge clk);
    if (req_ack != '0) begin
      int   idx;
      exp_t e;
      idx = 0;
      for (int k = 0; k < NR; k++) if (req_ack[k]) idx = k;
      chk("ack_onehot", 32'($onehot(req_ack)), 32'd1);
      chk("ack_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("ack_index", 32'(idx), 32'(e.id));
        chk("ack_grant_id", 32'(grant_id), 32'(e.id));
        chk("ack_tx_data", 32'(tx_data), 32'(e.data));
      end
      acks++;
      in_drain = 1'b1;
      if (!keep[idx]) req_valid[idx] = 1'b0;
    end else if (in_drain) begin
      chk("drain_stb_low", 32'(tx_stb), 32'd0);
      if (!active) in_drain = 1'b0;
    end
    if (tx_stb) stb_run++;
    else if (stb_run != 0) begin
      last_stb_len = stb_run;
      stb_fell     = 1'b1;
      stb_run      = 0;
    end
    if (mode == 1) begin
      if (tx_busy) begin
        busy_cnt++;
        if (busy_cnt >= BUSY_LEN) tx_busy = 1'b0;
      end else if (tx_stb) begin
        hi_cnt++;
        if (hi_cnt == BUSY_DLY) begin
          tx_busy  = 1'b1;
          busy_cnt = 0;
          hi_cnt   = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    keep      = '0;
    mode      = 0;
    hi_cnt    = 0;
    busy_cnt  = 0;
    in_drain  = 1'b0;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();
  endtask

  task automatic wait_acks(input int target);
    int budget;
    budget = 2000;
    while (acks < target && budget > 0) begin
      step();
      budget--;
    end
    chk("wait_acks_bound", 32'(acks >= target), 32'd1);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 2000;
    while ((active || tx_busy) && budget > 0) begin
      step();
      budget--;
    end
    chk("wait_idle_bound", 32'(!active && !tx_busy), 32'd1);
    step();
  endtask

  task automatic wait_stb_fall();
    int budget;
    budget = 500;
    stb_fell = 1'b0;
    while (!stb_fell && budget > 0) begin
      step();
      budget--;
    end
    chk("wait_stb_fall_bound", 32'(stb_fell), 32'd1);
  endtask

  task automatic wait_stb_rise();
    int budget;
    budget = 500;
    while (!tx_stb && budget > 0) begin
      step();
      budget--;
    end
    chk("wait_stb_rise_bound", 32'(tx_stb), 32'd1);
  endtask

  initial begin
    int target;
    bit seen;

    // Reset state
    step();
    step();
    chk("rst_tx_stb", 32'(tx_stb), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Single request
    mode = 1;
    expect_tx(0);
    req_valid = 4'b0001;
    step();
    chk("single_active", 32'(active), 32'd1);
    chk("single_stb_not_yet", 32'(tx_stb), 32'd0);
    chk("single_grant_id", 32'(grant_id), 32'd0);
    chk("single_tx_data", 32'(tx_data), 32'h41);
    step();
    chk("single_stb_rise", 32'(tx_stb), 32'd1);
    wait_stb_fall();
    chk("single_stb_len", 32'(last_stb_len), 32'(BUSY_DLY + 2));
    wait_acks(1);
    wait_idle();
    chk("single_active_low", 32'(active), 32'd0);
    chk("single_no_timeout", 32'(timeout_err), 32'd0);
    chk("single_data_kept", 32'(tx_data), 32'h41);

    // All four valid: served 0,1,2,3
    do_reset();
    mode = 1;
    for (int i = 0; i < NR; i++) expect_tx(i);
    req_valid = 4'b1111;
    wait_acks(acks + 4);
    wait_idle();

    // Fairness: 0 and 2 always pending, then 1 joins while rr points past 2
    do_reset();
    mode = 1;
    keep = 4'b0101;
    expect_tx(0); expect_tx(2); expect_tx(0); expect_tx(2);
    req_valid = 4'b0101;
    target = acks + 4;
    wait_acks(target);
    req_valid[1] = 1'b1;
    expect_tx(0); expect_tx(1); expect_tx(2);
    wait_acks(target + 3);
    keep = '0;
    req_valid = '0;
    wait_idle();

    // Strobe timeout with a silent transmitter, then the same requester retries
    do_reset();
    mode = 0;
    req_valid = 4'b0001;
    wait_stb_fall();
    chk("tmo_stb_len", 32'(last_stb_len), 32'(TMO));
    chk("tmo_err_set", 32'(timeout_err), 32'd1);
    chk("tmo_active_low", 32'(active), 32'd0);
    wait_stb_rise();
    chk("tmo_retry_grant", 32'(grant_id), 32'd0);
    mode = 1;
    hi_cnt = 0;
    expect_tx(0);
    wait_acks(acks + 1);
    wait_idle();
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);

    // Transmitter busy across reset release
    tx_busy   = 1'b1;
    rst       = 1'b1;
    mode      = 0;
    keep      = '0;
    in_drain  = 1'b0;
    req_valid = 4'b0001;
    step();
    step();
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (tx_stb) seen = 1'b1;
    end
    chk("busy_rst_no_stb", 32'(seen), 32'd0);
    chk("busy_rst_err_cleared", 32'(timeout_err), 32'd0);
    tx_busy = 1'b0;
    repeat (3) begin
      step();
      chk("busy_release_hold", 32'(tx_stb), 32'd0);
    end
    step();
    chk("busy_release_grant", 32'(tx_stb), 32'd1);
    mode = 1;
    hi_cnt = 0;
    expect_tx(0);
    wait_acks(acks + 1);
    wait_idle();

    // Reset during STROBE restarts rr at 0
    do_reset();
    mode = 1;
    expect_tx(1);
    req_valid = 4'b0010;
    wait_acks(acks + 1);
    wait_idle();
    mode = 0;
    req_valid = 4'b1010;
    wait_stb_rise();
    chk("mid_grant_from_rr2", 32'(grant_id), 32'd3);
    rst = 1'b1;
    step();
    chk("mid_rst_stb", 32'(tx_stb), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
    chk("mid_rst_req_ack", 32'(req_ack), 32'd0);
    rst = 1'b0;
    mode = 1;
    hi_cnt = 0;
    expect_tx(1);
    expect_tx(3);
    wait_acks(acks + 2);
    wait_idle();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
